// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus: hazard-unit stalls, predictor and decode-resolution inputs,
// plus the fetch/decode PCs and statistics driven back out by the fetch unit.
interface fetch_pc_unit_if #(
  parameter int unsigned CNT_W = 16
) ();

  logic             Stall_F;
  logic             Stall_D;
  logic             Branch_D;
  logic             Branch_Predictor_sel;
  logic [31:0]      Branch_predictor_target;
  logic             Misprediction_for_taken;
  logic             Misprediction_for_not_taken;
  logic [31:0]      PCBranch_result_D;

  logic [31:0]      PC_F;
  logic [31:0]      PCPlus4_F;
  logic [31:0]      PC_D;
  logic             Predicted_taken_D;
  logic             Valid_D;
  logic             Redirect;
  logic [CNT_W-1:0] Branch_cnt;
  logic [CNT_W-1:0] Mispredict_cnt;
  logic             Err;

  // Fetch unit side.
  modport master (
    input  Stall_F,
    input  Stall_D,
    input  Branch_D,
    input  Branch_Predictor_sel,
    input  Branch_predictor_target,
    input  Misprediction_for_taken,
    input  Misprediction_for_not_taken,
    input  PCBranch_result_D,
    output PC_F,
    output PCPlus4_F,
    output PC_D,
    output Predicted_taken_D,
    output Valid_D,
    output Redirect,
    output Branch_cnt,
    output Mispredict_cnt,
    output Err
  );

  // Surrounding pipeline: hazard unit, predictor and decode stage.
  modport slave (
    output Stall_F,
    output Stall_D,
    output Branch_D,
    output Branch_Predictor_sel,
    output Branch_predictor_target,
    output Misprediction_for_taken,
    output Misprediction_for_not_taken,
    output PCBranch_result_D,
    input  PC_F,
    input  PCPlus4_F,
    input  PC_D,
    input  Predicted_taken_D,
    input  Valid_D,
    input  Redirect,
    input  Branch_cnt,
    input  Mispredict_cnt,
    input  Err
  );

endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch-stage next-PC selection, IF/ID PC register, misprediction recovery and
// saturating branch/misprediction statistics.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic            clk,
  input  logic            rst,
  fetch_pc_unit_if.master bus
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StRecover
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_f_q, pc_f_d;
  logic [31:0]      pc_d_q, pc_d_d;
  logic             ptd_q, ptd_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
  logic             err_q, err_d;

  logic        qual;
  logic        mt;
  logic        mn;
  logic        redirect;
  logic        hold;
  logic        branch_inc;
  logic [31:0] pc_f_plus4;
  logic [31:0] pc_d_plus4;
  logic [31:0] pc_next;

  // Decode-stage events only count when decode holds a live, advancing instruction.
  assign qual       = valid_q & ~bus.Stall_D;
  assign mt         = bus.Misprediction_for_taken & qual;
  assign mn         = bus.Misprediction_for_not_taken & qual;
  assign redirect   = mt | mn;
  assign hold       = (bus.Stall_F | bus.Stall_D) & ~redirect;
  assign branch_inc = bus.Branch_D & qual;

  assign pc_f_plus4 = pc_f_q + 32'd4;
  assign pc_d_plus4 = pc_d_q + 32'd4;

  always_comb begin
    pc_next = pc_f_plus4;
    if (mt) begin
      pc_next = bus.PCBranch_result_D;
    end else if (mn) begin
      pc_next = pc_d_plus4;
    end else if (bus.Branch_Predictor_sel) begin
      pc_next = bus.Branch_predictor_target;
    end
  end

  always_comb begin
    pc_f_d        = pc_f_q;
    pc_d_d        = pc_d_q;
    ptd_d         = ptd_q;
    valid_d       = valid_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    err_d         = err_q | (mt & mn);

    if (!hold) begin
      pc_f_d  = pc_next;
      pc_d_d  = pc_f_q;
      // A redirect squashes whatever was fetched on the wrong path.
      ptd_d   = bus.Branch_Predictor_sel & ~redirect;
      valid_d = ~redirect & (state_q != StBoot);
    end

    if (branch_inc && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + CntOne;
    end
    if (redirect && (mispred_cnt_q != '1)) begin
      mispred_cnt_d = mispred_cnt_q + CntOne;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:    if (!hold) state_d = StRun;
      StRun:     if (redirect) state_d = StRecover;
      StRecover: if (!hold) state_d = StRun;
      default:   state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StBoot;
      pc_f_q        <= RESET_PC;
      pc_d_q        <= 32'h0000_0000;
      ptd_q         <= 1'b0;
      valid_q       <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_f_q        <= pc_f_d;
      pc_d_q        <= pc_d_d;
      ptd_q         <= ptd_d;
      valid_q       <= valid_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      err_q         <= err_d;
    end
  end

  assign bus.PC_F              = pc_f_q;
  assign bus.PCPlus4_F         = pc_f_plus4;
  assign bus.PC_D              = pc_d_q;
  assign bus.Predicted_taken_D = ptd_q;
  assign bus.Valid_D           = valid_q;
  assign bus.Redirect          = redirect;
  assign bus.Branch_cnt        = branch_cnt_q;
  assign bus.Mispredict_cnt    = mispred_cnt_q;
  assign bus.Err               = err_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: the driver queues hand-computed expectations
// per cycle, an independent monitor pops and compares them against both instances.
module tb_fetch_pc_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_pc_unit_if #(.CNT_W(16)) bus ();
  fetch_pc_unit_if #(.CNT_W(2))  bus_s ();

  fetch_pc_unit #(.RESET_PC(32'h0000_0000), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Narrow-counter copy sharing the same stimulus, for saturation.
  fetch_pc_unit #(.RESET_PC(32'h0000_0000), .CNT_W(2)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  assign bus_s.Stall_F                     = bus.Stall_F;
  assign bus_s.Stall_D                     = bus.Stall_D;
  assign bus_s.Branch_D                    = bus.Branch_D;
  assign bus_s.Branch_Predictor_sel        = bus.Branch_Predictor_sel;
  assign bus_s.Branch_predictor_target     = bus.Branch_predictor_target;
  assign bus_s.Misprediction_for_taken     = bus.Misprediction_for_taken;
  assign bus_s.Misprediction_for_not_taken = bus.Misprediction_for_not_taken;
  assign bus_s.PCBranch_result_D           = bus.PCBranch_result_D;

  always #5 clk = ~clk;

  typedef struct {
    logic        redir;
    logic [31:0] pc_f;
    logic [31:0] pc_d;
    logic        ptd;
    logic        vld;
    logic [15:0] bc;
    logic [15:0] mc;
    logic        err;
    logic [1:0]  bc2;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL vec%0d %s: got %h expected %h", vec, name, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the expected Redirect for this cycle and
  // the expected state after the following rising edge.
  task automatic step(input logic r, sf, sd, br, sel, input logic [31:0] tgt,
                      input logic mt, mn, input logic [31:0] pcb,
                      input logic e_redir, input logic [31:0] e_pcf, e_pcd,
                      input logic e_ptd, e_vld, input int e_bc, e_mc, input logic e_err);
    exp_t e;
    @(negedge clk);
    rst                             = r;
    bus.Stall_F                     = sf;
    bus.Stall_D                     = sd;
    bus.Branch_D                    = br;
    bus.Branch_Predictor_sel        = sel;
    bus.Branch_predictor_target     = tgt;
    bus.Misprediction_for_taken     = mt;
    bus.Misprediction_for_not_taken = mn;
    bus.PCBranch_result_D           = pcb;
    e.redir = e_redir;
    e.pc_f  = e_pcf;
    e.pc_d  = e_pcd;
    e.ptd   = e_ptd;
    e.vld   = e_vld;
    e.bc    = 16'(e_bc);
    e.mc    = 16'(e_mc);
    e.err   = e_err;
    e.bc2   = (e_bc > 3) ? 2'd3 : 2'(e_bc);
    sb_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("Redirect", {31'd0, bus.Redirect}, {31'd0, e.redir});
        @(posedge clk);
        #1;
        chk("PC_F", bus.PC_F, e.pc_f);
        chk("PCPlus4_F", bus.PCPlus4_F, e.pc_f + 32'd4);
        chk("PC_D", bus.PC_D, e.pc_d);
        chk("Predicted_taken_D", {31'd0, bus.Predicted_taken_D}, {31'd0, e.ptd});
        chk("Valid_D", {31'd0, bus.Valid_D}, {31'd0, e.vld});
        chk("Branch_cnt", {16'd0, bus.Branch_cnt}, {16'd0, e.bc});
        chk("Mispredict_cnt", {16'd0, bus.Mispredict_cnt}, {16'd0, e.mc});
        chk("Err", {31'd0, bus.Err}, {31'd0, e.err});
        chk("Branch_cnt_w2", {30'd0, bus_s.Branch_cnt}, {30'd0, e.bc2});
        vec++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin : driver
    bus.Stall_F                     = 1'b0;
    bus.Stall_D                     = 1'b0;
    bus.Branch_D                    = 1'b0;
    bus.Branch_Predictor_sel        = 1'b0;
    bus.Branch_predictor_target     = 32'h0;
    bus.Misprediction_for_taken     = 1'b0;
    bus.Misprediction_for_not_taken = 1'b0;
    bus.PCBranch_result_D           = 32'h0;

    //   rst sf sd br sel tgt           mt mn pcb          | rdr PC_F          PC_D          ptd vld bc mc err
    // Reset state, then sequential fetch; decode invalid during BOOT.
    step(1, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0000_0000, 32'h0000_0000, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0000_0004, 32'h0000_0000, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0000_0008, 32'h0000_0004, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0000_000C, 32'h0000_0008, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0000_0010, 32'h0000_000C, 0, 1, 0, 0, 0);
    // Predicted-taken jumps.
    step(0, 0, 0, 0, 1, 32'h20,       0, 0, 32'h0,         0, 32'h0000_0020, 32'h0000_0010, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h100,      0, 0, 32'h0,         0, 32'h0000_0100, 32'h0000_0020, 1, 1, 0, 0, 0);
    // Not-taken misprediction: recover to PC_D+4, one bubble.
    step(0, 0, 0, 0, 0, 32'h0,        0, 1, 32'h0,         1, 32'h0000_0024, 32'h0000_0100, 0, 0, 0, 1, 0);
    // Flags and branch with Valid_D=0 are ignored.
    step(0, 0, 0, 1, 0, 32'h0,        0, 1, 32'h0,         0, 32'h0000_0028, 32'h0000_0024, 0, 1, 0, 1, 0);
    // Taken misprediction overrides Stall_F.
    step(0, 1, 0, 1, 0, 32'h0,        1, 0, 32'h200,       1, 32'h0000_0200, 32'h0000_0028, 0, 0, 1, 2, 0);
    step(0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0000_0204, 32'h0000_0200, 0, 1, 1, 2, 0);
    // Stall_D masks the misprediction and the branch; everything holds.
    step(0, 0, 1, 1, 0, 32'h0,        1, 0, 32'h200,       0, 32'h0000_0204, 32'h0000_0200, 0, 1, 1, 2, 0);
    step(0, 1, 0, 0, 1, 32'h500,      0, 0, 32'h0,         0, 32'h0000_0204, 32'h0000_0200, 0, 1, 1, 2, 0);
    step(0, 0, 0, 1, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0000_0208, 32'h0000_0204, 0, 1, 2, 2, 0);
    // Both flags: taken path wins, single count, sticky Err.
    step(0, 0, 0, 1, 0, 32'h0,        1, 1, 32'h300,       1, 32'h0000_0300, 32'h0000_0208, 0, 0, 3, 3, 1);
    step(0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0000_0304, 32'h0000_0300, 0, 1, 3, 3, 1);
    step(0, 0, 0, 1, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0000_0308, 32'h0000_0304, 0, 1, 4, 3, 1);
    step(0, 0, 0, 1, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0000_030C, 32'h0000_0308, 0, 1, 5, 3, 1);
    // Reset mid-stream beats a live redirect.
    step(1, 0, 0, 1, 1, 32'h700,      1, 0, 32'h400,       1, 32'h0000_0000, 32'h0000_0000, 0, 0, 0, 0, 0);
    // Wrap of PC_F+4 and of PC_D+4.
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,        0, 32'hFFFF_FFFC, 32'h0000_0000, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0000_0000, 32'hFFFF_FFFC, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 32'h0,        0, 1, 32'h0,         1, 32'h0000_0000, 32'h0000_0000, 0, 0, 0, 1, 0);

    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch-stage next-PC generator and IF/ID PC pipeline register.
- Drives PC_F into the instruction memory and the branch predictor; consumes the predictor's taken-select, predicted target and misprediction pulses.
- Recovers from mispredictions and keeps saturating branch/misprediction statistics counters.
- Sits directly downstream of the branch predictor and upstream of the decode stage.

Parameters:
RESET_PC, 32'h0000_0000, PC_F value loaded on reset.
CNT_W, 16, width of each statistics counter.

Ports:
clk  in  1  single clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
Stall_F  in  1  hazard-unit fetch stall
Stall_D  in  1  hazard-unit decode stall; Stall_D=1 always implies hold of PC_F (treated as Stall_F|Stall_D)
Branch_D  in  1  branch instruction present in decode
Branch_Predictor_sel  in  1  predictor says taken and BTB hit for PC_F
Branch_predictor_target  in  32  predicted target for PC_F
Misprediction_for_taken  in  1  branch in D taken but predicted not-taken
Misprediction_for_not_taken  in  1  branch in D not taken but predicted taken
PCBranch_result_D  in  32  resolved branch target from decode
PC_F  out  32  current fetch PC
PCPlus4_F  out  32  PC_F+4
PC_D  out  32  PC of instruction in decode
Predicted_taken_D  out  1  Branch_Predictor_sel captured with PC_D
Valid_D  out  1  decode slot holds a non-flushed instruction
Redirect  out  1  combinational: a qualified misprediction this cycle
Branch_cnt  out  CNT_W  qualified branches resolved
Mispredict_cnt  out  CNT_W  qualified mispredictions
Err  out  1  sticky: both misprediction flags asserted in one qualified cycle

Behaviour:
- Reset (rst=1 at edge): PC_F=RESET_PC, PC_D=0, Predicted_taken_D=0, Valid_D=0, Branch_cnt=0, Mispredict_cnt=0, Err=0, state=BOOT. Reset mid-operation discards everything in the same edge.
- Qualification: mt = Misprediction_for_taken & Valid_D & ~Stall_D; mn = Misprediction_for_not_taken & Valid_D & ~Stall_D. Redirect = mt|mn.
- Next PC priority: mt -> PCBranch_result_D; else mn -> PC_D+4; else Branch_Predictor_sel -> Branch_predictor_target; else PC_F+4. All adds are 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- Hold: when Stall_F|Stall_D and no Redirect, PC_F, PC_D, Predicted_taken_D and Valid_D all hold. Redirect is only possible with Stall_D=0 and overrides Stall_F, so PC_F loads the redirect target.
- IF/ID register, when not holding: PC_D<=PC_F, Predicted_taken_D<=Branch_Predictor_sel, Valid_D<=~Redirect & (state!=BOOT). On Redirect: Valid_D<=0 (one-cycle bubble), Predicted_taken_D<=0.
- FSM:
  - BOOT: first cycle after reset; decode is invalid. Leaves to RUN on the first non-held edge.
  - RUN: normal operation. Goes to RECOVER on Redirect.
  - RECOVER: one cycle with decode flushed. Returns to RUN on the next non-held edge; another Redirect is impossible because Valid_D=0.
- Latency: PC_F changes one edge after the decision. A misprediction seen in D puts the correct PC in PC_F at the next edge, so the penalty is one bubble.
- Counters: Branch_cnt increments on Branch_D & Valid_D & ~Stall_D. Mispredict_cnt increments on Redirect. Both saturate at all-ones and never wrap.
- Simultaneous mt & mn (illegal): mt wins, Mispredict_cnt increments by 1, and Err sets and stays set until rst.
- Unqualified misprediction flags (Valid_D=0 or Stall_D=1) are ignored entirely.

Test Plan:
1. Reset, no stalls, sel=0 for 4 cycles -> PC_F sequence 0,4,8,C,10. Valid_D=0 during the first decode cycle, then 1.
2. PC_F=0x20 with sel=1, target=0x100 -> next PC_F=0x100, PC_D=0x20, Predicted_taken_D=1.
3. PC_D=0x20 with Valid_D=1, Misprediction_for_not_taken=1 -> Redirect=1, next PC_F=0x24, Valid_D=0, Mispredict_cnt +1.
4. Misprediction_for_taken=1, PCBranch_result_D=0x200, Stall_F=1, Stall_D=0 -> PC_F=0x200 despite stall. With Stall_D=1 instead -> ignored and PC_F holds.
5. Both misprediction flags set with PCBranch_result_D=0x300 -> PC_F=0x300, Err=1 and stays 1. Assert rst mid-stream -> PC_F=RESET_PC and Err=0 at the same edge.
6. CNT_W=2 with 5 qualified branches -> Branch_cnt ends at 3 (saturated); PC_F=0xFFFF_FFFC with sel=0 -> next PC_F=0.
